// File: rtl/rv_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   PARCEL_W           : width of one instruction parcel (halfword)
//   OPCODE_QUADRANT_32 : low two bits that mark a 32-bit instruction
//   parcel_t           : one halfword parcel
package rv_pkg;

  localparam int PARCEL_W = 16;
  localparam logic [1:0] OPCODE_QUADRANT_32 = 2'b11;

  typedef logic [PARCEL_W-1:0] parcel_t;

  // A parcel whose quadrant bits are 2'b11 starts a 32-bit instruction.
  function automatic logic is_32bit(input parcel_t p);
    return (p[1:0] == OPCODE_QUADRANT_32);
  endfunction

endpackage

// File: rtl/parcel_buffer.sv
// Three-entry halfword shift buffer (entry 0 is the oldest parcel).
// Ports:
//   clk, arstn        : clock, synchronous active-low reset
//   flush             : drop all parcels (count -> 0)
//   pop1 / pop2       : remove one / two parcels from the head
//   push1 / push2     : append push_a / push_a then push_b after popping
//   push_a, push_b    : parcels to append
//   hw0, hw1          : two oldest parcels
//   count             : number of valid parcels (0..3)
module parcel_buffer
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        arstn,
  input  logic        flush,
  input  logic        pop1,
  input  logic        pop2,
  input  logic        push1,
  input  logic        push2,
  input  logic [15:0] push_a,
  input  logic [15:0] push_b,
  output logic [15:0] hw0,
  output logic [15:0] hw1,
  output logic [1:0]  count
);

  parcel_t    buf_q   [3];
  parcel_t    shifted [3];
  parcel_t    buf_d   [3];
  logic [1:0] count_q;
  logic [1:0] cnt_pop;
  logic [1:0] cnt_d;

  // Pop stage: shift surviving parcels towards the head.
  always_comb begin
    shifted = buf_q;
    cnt_pop = count_q;
    if (pop2) begin
      shifted[0] = buf_q[2];
      shifted[1] = 16'h0000;
      shifted[2] = 16'h0000;
      cnt_pop    = count_q - 2'd2;
    end else if (pop1) begin
      shifted[0] = buf_q[1];
      shifted[1] = buf_q[2];
      shifted[2] = 16'h0000;
      cnt_pop    = count_q - 2'd1;
    end else begin
      shifted = buf_q;
      cnt_pop = count_q;
    end
  end

  // Append stage: new parcels land right behind what survived the pop.
  always_comb begin
    buf_d = shifted;
    cnt_d = cnt_pop;
    for (int i = 0; i < 3; i++) begin
      if ((push1 || push2) && (3'(i) == {1'b0, cnt_pop})) begin
        buf_d[i] = push_a;
      end else if (push2 && (3'(i) == ({1'b0, cnt_pop} + 3'd1))) begin
        buf_d[i] = push_b;
      end else begin
        buf_d[i] = shifted[i];
      end
    end
    if (flush) begin
      cnt_d = 2'd0;
    end else if (push2) begin
      cnt_d = cnt_pop + 2'd2;
    end else if (push1) begin
      cnt_d = cnt_pop + 2'd1;
    end else begin
      cnt_d = cnt_pop;
    end
  end

  // Buffer storage and occupancy.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      buf_q   <= '{default: 16'h0000};
      count_q <= 2'd0;
    end else begin
      buf_q   <= buf_d;
      count_q <= cnt_d;
    end
  end

  assign hw0   = buf_q[0];
  assign hw1   = buf_q[1];
  assign count = count_q;

endmodule

// File: rtl/fetch_aligner.sv
// Instruction-fetch aligner: fetches words, buffers halfword parcels and
// presents compressed / 32-bit instructions (possibly straddling words).
// Ports:
//   clk, arstn                 : clock, synchronous active-low reset
//   redirect, redirectPc       : load new PC and flush the buffer
//   memReq, memAddr, memGnt    : word-aligned request handshake
//   memRvalid, memRdata        : read response (little-endian parcels)
//   instrValid, instrReady     : decode handshake
//   instr, instrPc,
//   instrCompressed            : presented instruction, its PC, 16-bit flag
module fetch_aligner
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memGnt,
  input  logic        memRvalid,
  input  logic [31:0] memRdata,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instr,
  output logic [31:0] instrPc,
  output logic        instrCompressed
);

  logic [31:0] fetch_addr;
  logic [31:0] pc;
  logic        outstanding;
  logic        discard;
  logic        drop_low;

  logic [15:0] hw0;
  logic [15:0] hw1;
  logic [1:0]  count;

  logic        valid_s;
  logic        comp_s;
  logic [31:0] instr_s;
  logic        consume;
  logic        rsp_take;
  logic        grant;

  parcel_buffer u_buf (
    .clk    (clk),
    .arstn  (arstn),
    .flush  (redirect),
    .pop1   (consume & comp_s),
    .pop2   (consume & ~comp_s),
    .push1  (rsp_take & drop_low),
    .push2  (rsp_take & ~drop_low),
    .push_a (drop_low ? memRdata[31:16] : memRdata[15:0]),
    .push_b (memRdata[31:16]),
    .hw0    (hw0),
    .hw1    (hw1),
    .count  (count)
  );

  // Extraction: head parcel decides 16- or 32-bit; a 32-bit one waits for hw1.
  always_comb begin
    valid_s = 1'b0;
    comp_s  = 1'b0;
    instr_s = 32'h0000_0000;
    if ((count != 2'd0) && !is_32bit(hw0)) begin
      valid_s = 1'b1;
      comp_s  = 1'b1;
      instr_s = {16'h0000, hw0};
    end else if ((count >= 2'd2) && is_32bit(hw0)) begin
      valid_s = 1'b1;
      comp_s  = 1'b0;
      instr_s = {hw1, hw0};
    end else begin
      valid_s = 1'b0;
    end
  end

  // Redirect overrides any consume or response in the same cycle.
  assign consume  = valid_s & instrReady & ~redirect;
  assign rsp_take = memRvalid & outstanding & ~discard & ~redirect;
  // Requesting only at count <= 1 keeps the buffer from ever overflowing.
  assign memReq   = arstn & (count <= 2'd1) & ~outstanding & ~redirect;
  assign grant    = memReq & memGnt;

  assign memAddr         = fetch_addr;
  assign instrValid      = valid_s;
  assign instr           = instr_s;
  assign instrCompressed = comp_s;
  assign instrPc         = pc;

  // Request tracking, fetch address, PC and misaligned-entry state.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      fetch_addr  <= RESET_PC;
      pc          <= RESET_PC;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      drop_low    <= 1'b0;
    end else if (redirect) begin
      pc          <= redirectPc & ~32'h0000_0001;
      fetch_addr  <= {redirectPc[31:2], 2'b00};
      drop_low    <= redirectPc[1];
      // A response landing this very cycle is simply dropped; otherwise the
      // in-flight one must be swallowed when it arrives.
      outstanding <= outstanding & ~memRvalid;
      discard     <= outstanding & ~memRvalid;
    end else begin
      if (grant) begin
        outstanding <= 1'b1;
        fetch_addr  <= fetch_addr + 32'd4;
      end else if (memRvalid && outstanding) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
        if (!discard) begin
          drop_low <= 1'b0;
        end
      end
      if (consume) begin
        pc <= pc + (comp_s ? 32'd2 : 32'd4);
      end
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
module tb_fetch_aligner;

  logic        clk = 1'b0;
  logic        arstn;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memGnt;
  logic        memRvalid;
  logic [31:0] memRdata;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic        instrCompressed;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:255];
  int          lat = 1;

  logic        g_s;
  logic [31:0] a_s;
  logic        p_v = 1'b0;
  logic [31:0] p_d = 32'h0;

  logic [31:0] ev_instr [$];
  logic [31:0] ev_pc    [$];
  logic        ev_c     [$];
  logic [31:0] gr_addr  [$];
  int          first_valid;

  always #5 clk = ~clk;

  fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .arstn           (arstn),
    .redirect        (redirect),
    .redirectPc      (redirectPc),
    .memReq          (memReq),
    .memAddr         (memAddr),
    .memGnt          (memGnt),
    .memRvalid       (memRvalid),
    .memRdata        (memRdata),
    .instrValid      (instrValid),
    .instrReady      (instrReady),
    .instr           (instr),
    .instrPc         (instrPc),
    .instrCompressed (instrCompressed)
  );

  // Memory model: a grant at edge N responds at edge N+lat.
  always @(posedge clk) begin
    g_s = memReq & memGnt;
    a_s = memAddr;
    #1;
    if (lat == 2) begin
      memRvalid = p_v;
      memRdata  = p_v ? p_d : 32'h0;
    end else begin
      memRvalid = g_s;
      memRdata  = g_s ? mem[a_s[9:2]] : 32'h0;
    end
    p_v = g_s;
    p_d = mem[a_s[9:2]];
  end

  task automatic fill_mem(input logic [31:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic do_reset();
    arstn      = 1'b0;
    redirect   = 1'b0;
    redirectPc = 32'h0;
    instrReady = 1'b1;
    memGnt     = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Record consumed instructions and grants over n cycles, starting now.
  task automatic collect(input int n);
    ev_instr.delete(); ev_pc.delete(); ev_c.delete(); gr_addr.delete();
    first_valid = -1;
    for (int i = 0; i < n; i++) begin
      #1;
      if (instrValid && first_valid < 0) first_valid = i;
      if (instrValid && instrReady && !redirect) begin
        ev_instr.push_back(instr);
        ev_pc.push_back(instrPc);
        ev_c.push_back(instrCompressed);
      end
      if (memReq && memGnt) gr_addr.push_back(memAddr);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    lat = 1;
    memRvalid = 1'b0;
    memRdata  = 32'h0;
    fill_mem(32'h0000_0013);
    do_reset();
    n_checks++; if (memReq !== 1'b0) begin n_fail++; $display("FAIL reset_memReq: got %b want 0", memReq); end
    n_checks++; if (instrValid !== 1'b0) begin n_fail++; $display("FAIL reset_instrValid: got %b want 0", instrValid); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
    n_checks++; if (instrCompressed !== 1'b0) begin n_fail++; $display("FAIL reset_compressed: got %b want 0", instrCompressed); end
    n_checks++; if (instrPc !== 32'h0) begin n_fail++; $display("FAIL reset_instrPc: got %h want 0", instrPc); end
    n_checks++; if (memAddr !== 32'h0) begin n_fail++; $display("FAIL reset_memAddr: got %h want 0", memAddr); end
  endtask

  task automatic test_all32();
    logic [31:0] e_p [3] = '{32'h0, 32'h4, 32'h8};
    lat = 1;
    fill_mem(32'h0000_0013);
    do_reset();
    arstn = 1'b1;
    collect(14);
    n_checks++; if (first_valid !== 2) begin n_fail++; $display("FAIL all32_latency: got %0d want 2", first_valid); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (k >= ev_pc.size()) begin n_fail++; $display("FAIL all32_instr%0d: missing, want pc %h", k, e_p[k]); end
      else if (ev_instr[k] !== 32'h13 || ev_pc[k] !== e_p[k] || ev_c[k] !== 1'b0) begin
        n_fail++; $display("FAIL all32_instr%0d: got %h@%h c=%b want 00000013@%h c=0", k, ev_instr[k], ev_pc[k], ev_c[k], e_p[k]);
      end
      n_checks++;
      if (k >= gr_addr.size()) begin n_fail++; $display("FAIL all32_addr%0d: missing, want %h", k, e_p[k]); end
      else if (gr_addr[k] !== e_p[k]) begin n_fail++; $display("FAIL all32_addr%0d: got %h want %h", k, gr_addr[k], e_p[k]); end
    end
  endtask

  task automatic test_compressed();
    logic [31:0] e_i [3] = '{32'h1, 32'h1, 32'h13};
    logic [31:0] e_p [3] = '{32'h0, 32'h2, 32'h4};
    logic        e_c [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] e_g [2] = '{32'h0, 32'h4};
    lat = 1;
    fill_mem(32'h0000_0013);
    mem[0] = 32'h0001_0001;
    do_reset();
    arstn = 1'b1;
    collect(10);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (k >= ev_pc.size()) begin n_fail++; $display("FAIL comp_instr%0d: missing, want pc %h", k, e_p[k]); end
      else if (ev_instr[k] !== e_i[k] || ev_pc[k] !== e_p[k] || ev_c[k] !== e_c[k]) begin
        n_fail++; $display("FAIL comp_instr%0d: got %h@%h c=%b want %h@%h c=%b", k, ev_instr[k], ev_pc[k], ev_c[k], e_i[k], e_p[k], e_c[k]);
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (k >= gr_addr.size()) begin n_fail++; $display("FAIL comp_addr%0d: missing, want %h", k, e_g[k]); end
      else if (gr_addr[k] !== e_g[k]) begin n_fail++; $display("FAIL comp_addr%0d: got %h want %h", k, gr_addr[k], e_g[k]); end
    end
  endtask

  task automatic test_straddle();
    logic [31:0] e_i [4] = '{32'h1, 32'h13, 32'h1, 32'h1};
    logic [31:0] e_p [4] = '{32'h0, 32'h2, 32'h6, 32'h8};
    logic        e_c [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] e_g [3] = '{32'h0, 32'h4, 32'h8};
    lat = 1;
    fill_mem(32'h0000_0013);
    mem[0] = 32'h0013_0001;
    mem[1] = 32'h0001_0000;
    mem[2] = 32'h0001_0001;
    do_reset();
    arstn = 1'b1;
    collect(16);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k >= ev_pc.size()) begin n_fail++; $display("FAIL strad_instr%0d: missing, want pc %h", k, e_p[k]); end
      else if (ev_instr[k] !== e_i[k] || ev_pc[k] !== e_p[k] || ev_c[k] !== e_c[k]) begin
        n_fail++; $display("FAIL strad_instr%0d: got %h@%h c=%b want %h@%h c=%b", k, ev_instr[k], ev_pc[k], ev_c[k], e_i[k], e_p[k], e_c[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (k >= gr_addr.size()) begin n_fail++; $display("FAIL strad_addr%0d: missing, want %h", k, e_g[k]); end
      else if (gr_addr[k] !== e_g[k]) begin n_fail++; $display("FAIL strad_addr%0d: got %h want %h", k, gr_addr[k], e_g[k]); end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] e_i [2] = '{32'h13, 32'h1};
    logic [31:0] e_p [2] = '{32'h102, 32'h106};
    logic        e_c [2] = '{1'b0, 1'b1};
    logic [31:0] e_g [2] = '{32'h100, 32'h104};
    logic        found = 1'b0;
    lat = 2;
    fill_mem(32'h0000_0013);
    mem[2]  = 32'h0001_0001;
    mem[64] = 32'h0013_0001;
    mem[65] = 32'h0001_0000;
    do_reset();
    arstn = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (memReq && memGnt && memAddr == 32'h8) found = 1'b1;
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL redir_find_req8: got %b want 1", found); end
    @(negedge clk);
    redirect   = 1'b1;
    redirectPc = 32'h0000_0102;
    #1;
    n_checks++; if (memReq !== 1'b0) begin n_fail++; $display("FAIL redir_memReq_held: got %b want 0", memReq); end
    @(negedge clk);
    redirect = 1'b0;
    collect(20);
    n_checks++; if (first_valid !== 7) begin n_fail++; $display("FAIL redir_latency: got %0d want 7", first_valid); end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (k >= ev_pc.size()) begin n_fail++; $display("FAIL redir_instr%0d: missing, want pc %h", k, e_p[k]); end
      else if (ev_instr[k] !== e_i[k] || ev_pc[k] !== e_p[k] || ev_c[k] !== e_c[k]) begin
        n_fail++; $display("FAIL redir_instr%0d: got %h@%h c=%b want %h@%h c=%b", k, ev_instr[k], ev_pc[k], ev_c[k], e_i[k], e_p[k], e_c[k]);
      end
      n_checks++;
      if (k >= gr_addr.size()) begin n_fail++; $display("FAIL redir_addr%0d: missing, want %h", k, e_g[k]); end
      else if (gr_addr[k] !== e_g[k]) begin n_fail++; $display("FAIL redir_addr%0d: got %h want %h", k, gr_addr[k], e_g[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e_i [4] = '{32'h13, 32'h1, 32'h5, 32'h9};
    logic [31:0] e_p [4] = '{32'h2, 32'h6, 32'h8, 32'hA};
    logic        e_c [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic        found = 1'b0;
    lat = 1;
    fill_mem(32'h0000_0013);
    mem[0] = 32'h0013_0001;
    mem[1] = 32'h0001_0000;
    mem[2] = 32'h0009_0005;
    do_reset();
    arstn = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (instrValid && instrPc == 32'h2) found = 1'b1;
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL bp_find_pc2: got %b want 1", found); end
    instrReady = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (instrValid !== 1'b1 || instr !== 32'h13 || instrPc !== 32'h2 || memReq !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b %h@%h req=%b want v=1 00000013@00000002 req=0", k, instrValid, instr, instrPc, memReq);
      end
    end
    instrReady = 1'b1;
    collect(12);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k >= ev_pc.size()) begin n_fail++; $display("FAIL bp_instr%0d: missing, want pc %h", k, e_p[k]); end
      else if (ev_instr[k] !== e_i[k] || ev_pc[k] !== e_p[k] || ev_c[k] !== e_c[k]) begin
        n_fail++; $display("FAIL bp_instr%0d: got %h@%h c=%b want %h@%h c=%b", k, ev_instr[k], ev_pc[k], ev_c[k], e_i[k], e_p[k], e_c[k]);
      end
    end
    n_checks++;
    if (gr_addr.size() < 1) begin n_fail++; $display("FAIL bp_addr0: missing, want 00000008"); end
    else if (gr_addr[0] !== 32'h8) begin n_fail++; $display("FAIL bp_addr0: got %h want 00000008", gr_addr[0]); end
  endtask

  task automatic test_reset_midfetch();
    logic found = 1'b0;
    lat = 2;
    fill_mem(32'h0000_0013);
    mem[1] = 32'h0001_0001;
    do_reset();
    arstn = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (memReq && memGnt && memAddr == 32'h4) found = 1'b1;
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rmid_find_req4: got %b want 1", found); end
    @(negedge clk);
    arstn = 1'b0;
    @(negedge clk);
    n_checks++; if (instrValid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid_after_reset: got %b want 0", instrValid); end
    n_checks++; if (instrPc !== 32'h0) begin n_fail++; $display("FAIL rmid_pc_after_reset: got %h want 0", instrPc); end
    arstn = 1'b1;
    collect(10);
    n_checks++; if (first_valid !== 3) begin n_fail++; $display("FAIL rmid_latency: got %0d want 3", first_valid); end
    n_checks++;
    if (gr_addr.size() < 1) begin n_fail++; $display("FAIL rmid_addr0: missing, want 00000000"); end
    else if (gr_addr[0] !== 32'h0) begin n_fail++; $display("FAIL rmid_addr0: got %h want 00000000", gr_addr[0]); end
    n_checks++;
    if (ev_pc.size() < 1) begin n_fail++; $display("FAIL rmid_instr0: missing, want 00000013@00000000"); end
    else if (ev_instr[0] !== 32'h13 || ev_pc[0] !== 32'h0 || ev_c[0] !== 1'b0) begin
      n_fail++; $display("FAIL rmid_instr0: got %h@%h c=%b want 00000013@00000000 c=0", ev_instr[0], ev_pc[0], ev_c[0]);
    end
  endtask

  initial begin
    test_reset();
    test_all32();
    test_compressed();
    test_straddle();
    test_redirect();
    test_backpressure();
    test_reset_midfetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
